// File: rtl/pdp_fifo_pkg.sv
// Shared constants and helpers for the pseudo-dual-port EBR FIFO controller.
package pdp_fifo_pkg;

    localparam int unsigned DATA_W       = 36;
    localparam int unsigned BE_W         = 4;

    localparam int unsigned DEF_ADDR_W   = 9;
    localparam int unsigned DEF_AF_LEVEL = 508;
    localparam int unsigned DEF_AE_LEVEL = 4;

    localparam string REGMODE_NOREG  = "NOREG";
    localparam string REGMODE_OUTREG = "OUTREG";

    // EBR read latency in cycles for a given output register mode.
    function automatic int unsigned lat(input string regmode);
        return (regmode == REGMODE_OUTREG) ? 2 : 1;
    endfunction

endpackage

// File: rtl/pdp_fifo_ctrl_if.sv
// Producer/consumer and EBR-side signal bundle of the FIFO controller.
interface pdp_fifo_ctrl_if import pdp_fifo_pkg::*; #(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

    logic              WR_EN;
    logic [DATA_W-1:0] DIN;
    logic              RD_EN;
    logic [DATA_W-1:0] DOUT;
    logic              DOUT_VALID;
    logic              FULL;
    logic              EMPTY;
    logic              ALMOST_FULL;
    logic              ALMOST_EMPTY;
    logic [ADDR_W:0]   COUNT;
    logic              OVERFLOW;
    logic              UNDERFLOW;
    logic [DATA_W-1:0] RAM_DI;
    logic              RAM_CEW;
    logic [ADDR_W-1:0] RAM_ADW;
    logic [BE_W-1:0]   RAM_BE;
    logic              RAM_CER;
    logic [ADDR_W-1:0] RAM_ADR;
    logic [DATA_W-1:0] RAM_DO;

    // FIFO controller side.
    modport slave (
        input  WR_EN, DIN, RD_EN, RAM_DO,
        output DOUT, DOUT_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW,
               RAM_DI, RAM_CEW, RAM_ADW, RAM_BE, RAM_CER, RAM_ADR
    );

    // Producer/consumer and RAM side.
    modport master (
        output WR_EN, DIN, RD_EN, RAM_DO,
        input  DOUT, DOUT_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW,
               RAM_DI, RAM_CEW, RAM_ADW, RAM_BE, RAM_CER, RAM_ADR
    );

endinterface

// File: rtl/pdp_fifo_flags.sv
// Occupancy arithmetic and registered status flags for the FIFO controller.
module pdp_fifo_flags import pdp_fifo_pkg::*; #(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned AF_LEVEL = DEF_AF_LEVEL,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic            wa,
    input  logic            ra,
    input  logic [ADDR_W:0] count,
    output logic [ADDR_W:0] count_next,
    output logic            full,
    output logic            empty,
    output logic            almost_full,
    output logic            almost_empty,
    output logic            overflow,
    output logic            underflow
);

    localparam int unsigned      CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH  = CNT_W'(1) << ADDR_W;
    localparam logic [CNT_W-1:0] AF_THR = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_THR = CNT_W'(AE_LEVEL);

    logic full_q, full_d;
    logic empty_q, empty_d;
    logic almost_full_q, almost_full_d;
    logic almost_empty_q, almost_empty_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Next occupancy and the flags derived from it; sticky error bits accumulate.
    always_comb begin
        count_next = count;
        if (wa && !ra) begin
            count_next = count + CNT_W'(1);
        end else if (ra && !wa) begin
            count_next = count - CNT_W'(1);
        end
        full_d         = (count_next == DEPTH);
        empty_d        = (count_next == '0);
        almost_full_d  = (count_next >= AF_THR);
        almost_empty_d = (count_next <= AE_THR);
        overflow_d     = overflow_q  | (wr_en & full_q);
        underflow_d    = underflow_q | (rd_en & empty_q);
    end

    // Flag registers; reset leaves the FIFO empty with errors cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: rtl/pdp_fifo_ctrl.sv
// FIFO controller for a 512x36 pseudo-dual-port EBR: pointers, RAM strobes,
// occupancy flags and a read-data strobe aligned to the EBR read latency.
module pdp_fifo_ctrl import pdp_fifo_pkg::*; #(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter string       REGMODE  = REGMODE_NOREG,
    parameter int unsigned AF_LEVEL = DEF_AF_LEVEL,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
    input logic              CLK,
    input logic              RST,
    pdp_fifo_ctrl_if.slave   bus
);

    localparam int unsigned LAT = lat(REGMODE);

    logic              wa, ra;
    logic              full, empty;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              dout_valid;

    assign wa = bus.WR_EN & ~full;
    assign ra = bus.RD_EN & ~empty;

    pdp_fifo_flags #(
        .ADDR_W   (ADDR_W),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) u_flags (
        .clk          (CLK),
        .rst          (RST),
        .wr_en        (bus.WR_EN),
        .rd_en        (bus.RD_EN),
        .wa           (wa),
        .ra           (ra),
        .count        (count_q),
        .count_next   (count_d),
        .full         (full),
        .empty        (empty),
        .almost_full  (bus.ALMOST_FULL),
        .almost_empty (bus.ALMOST_EMPTY),
        .overflow     (bus.OVERFLOW),
        .underflow    (bus.UNDERFLOW)
    );

    // Pointers advance once per accepted access and wrap naturally at the depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wa) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (ra) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    if (LAT > 1) begin : g_outreg
        logic [1:0] vld_q, vld_d;

        // Two-stage valid pipe matching the EBR output register.
        always_comb begin
            vld_d = {vld_q[0], ra};
        end

        // Valid pipe registers; reset drops reads still in flight.
        always_ff @(posedge CLK) begin
            if (RST) begin
                vld_q <= '0;
            end else begin
                vld_q <= vld_d;
            end
        end

        assign dout_valid = vld_q[1];
    end else begin : g_noreg
        logic vld_q, vld_d;

        // Single-stage valid pipe matching the unregistered EBR output.
        always_comb begin
            vld_d = ra;
        end

        // Valid register; reset drops a read still in flight.
        always_ff @(posedge CLK) begin
            if (RST) begin
                vld_q <= 1'b0;
            end else begin
                vld_q <= vld_d;
            end
        end

        assign dout_valid = vld_q;
    end

    assign bus.RAM_DI     = bus.DIN;
    assign bus.RAM_CEW    = wa;
    assign bus.RAM_ADW    = wr_ptr_q;
    assign bus.RAM_BE     = '1;
    assign bus.RAM_CER    = ra;
    assign bus.RAM_ADR    = rd_ptr_q;
    assign bus.DOUT       = bus.RAM_DO;
    assign bus.DOUT_VALID = dout_valid;
    assign bus.FULL       = full;
    assign bus.EMPTY      = empty;
    assign bus.COUNT      = count_q;

endmodule
